time_parameters_with_reprogrammability: RTL and testbench
=========================================================

# time_parameters_with_reprogrammability

Register file holding the four 4-bit time parameters of the anti-theft system: arm delay, driver-door delay, passenger-door delay and alarm-on duration. It drives the currently requested interval length to the system timer. Any parameter can be overwritten at run time through a reprogramming port. System reset restores the factory defaults.

## Interface
Parameters:
- `T_ARM_DELAY_DEFAULT`, default 4'd6: reset value of parameter index 0 (arm delay).
- `T_DRIVER_DELAY_DEFAULT`, default 4'd8: reset value of index 1 (driver-door delay).
- `T_PASSENGER_DELAY_DEFAULT`, default 4'd15: reset value of index 2 (passenger-door delay).
- `T_ALARM_ON_DEFAULT`, default 4'd10: reset value of index 3 (alarm-on duration).

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  system clock; all state changes on its rising edge.
- `systemReset`  in  1  synchronous active-high reset.
- `reprogram`  in  1  write request for the parameter selected by `timeParameterSelector`.
- `interval`  in  2  read select; drives `value`.
- `timeParameterSelector`  in  2  write select.
- `timeValue`  in  4  new parameter value.
- `value`  out  4  length of the selected interval in time units.

## Operation
- Index encoding for both `interval` and `timeParameterSelector`:
  - 00 = arm delay
  - 01 = driver delay
  - 10 = passenger delay
  - 11 = alarm on
- State is four 4-bit registers, P0..P3.
- Reset: when `systemReset` = 1 at a rising edge, P0..P3 load their `*_DEFAULT` values. Reset has priority over `reprogram`.
- Write: when `reprogram` = 1, `systemReset` = 0 and the write condition in Configuration holds, P[`timeParameterSelector`] <= `timeValue` at the rising edge. The other three registers hold.
- Read: `value` = P[`interval`], as a purely combinational mux with no registering.
- All 4-bit values 0..15 are stored verbatim. No clamping, no wrap, no validity check.
- Write and read of the same index in the same cycle: `value` shows the old content until the clock edge and the new content immediately after it.
- A write never disturbs an unselected register, including when `interval` differs from `timeParameterSelector`.
- Unknown `timeParameterSelector` or `timeValue` is only permitted while `reprogram` = 0. Unknown `interval` gives an unspecified `value` but must not corrupt state.

## Timing
- Read latency: 0 cycles, combinational from `interval` and register state.
- Write latency: 1 edge. The new value is visible on `value` right after the edge that samples `reprogram`.
- Reset latency: 1 edge. Before the first reset edge, register contents are unspecified.
- Reset asserted mid-write: reset wins and the written register returns to its default.
- No handshake and no busy state. A write may be issued every cycle.

## Configuration
- Macro `TPR_REPROG_EDGE_EN`.
- Defined: a write occurs only on the first cycle `reprogram` is high after being low, i.e. rising-edge detect through a 1-bit register cleared by reset. Holding `reprogram` high performs exactly one write, so later `timeValue` or `timeParameterSelector` changes while it stays high are ignored.
- Undefined: level-sensitive. Every edge with `reprogram` = 1 writes the current `timeValue`.
- Reset behaviour and read path are identical in both builds.

## Test plan
- Default readback: reset for 1+ cycles, release, sweep `interval` 00/01/10/11 -> `value` = 6, 8, 15, 10.
- Reprogram each parameter, one write per index with 12-cycle reprogram pulses:
  - index 00 <- 7
  - index 01 <- 4
  - index 10 <- 14
  - index 11 <- 9
  - Then sweep `interval` -> 7, 4, 14, 9.
- Isolation: with `interval` = 00 showing 6, write index 11 <- 3 -> `value` stays 6; `interval` = 11 -> 3.
- Same-index update: `interval` = 01, write 01 <- 12 -> `value` is 8 before the edge and 12 after it.
- Reset priority: `systemReset` = 1 and `reprogram` = 1 with index 10 <- 1 in the same cycle -> index 10 reads 15 after the edge.
- Edge mode (with `TPR_REPROG_EDGE_EN`): hold `reprogram` high while `timeValue` changes 5 -> 2 on index 00 -> `value` = 5. Without the macro -> `value` = 2.

Source files
------------

// File: rtl/time_parameters_with_reprogrammability_if.sv
// Reprogramming and read-select bundle between the anti-theft controller and
// its time-parameter register file.
interface time_parameters_with_reprogrammability_if;
  logic       reprogram;
  logic [1:0] interval;
  logic [1:0] timeParameterSelector;
  logic [3:0] timeValue;
  logic [3:0] value;

  modport master (
    output reprogram,
    output interval,
    output timeParameterSelector,
    output timeValue,
    input  value
  );

  modport slave (
    input  reprogram,
    input  interval,
    input  timeParameterSelector,
    input  timeValue,
    output value
  );
endinterface

// File: rtl/time_parameters_with_reprogrammability.sv
// Four 4-bit anti-theft time parameters with run-time reprogramming and a
// combinational read mux. Define TPR_REPROG_EDGE_EN for one write per reprogram pulse.
module time_parameters_with_reprogrammability #(
  parameter logic [3:0] T_ARM_DELAY_DEFAULT       = 4'd6,
  parameter logic [3:0] T_DRIVER_DELAY_DEFAULT    = 4'd8,
  parameter logic [3:0] T_PASSENGER_DELAY_DEFAULT = 4'd15,
  parameter logic [3:0] T_ALARM_ON_DEFAULT        = 4'd10
) (
  input  logic                                  clock,
  input  logic                                  systemReset,
  time_parameters_with_reprogrammability_if.slave bus
);

  logic [3:0] r_param [4];
  logic       w_write;

`ifdef TPR_REPROG_EDGE_EN
  logic r_reprog_d;

  always_ff @(posedge clock) begin
    if (systemReset) r_reprog_d <= 1'b0;
    else             r_reprog_d <= bus.reprogram;
  end

  assign w_write = bus.reprogram & ~r_reprog_d;
`else
  assign w_write = bus.reprogram;
`endif

  // Reset outranks a simultaneous write.
  always_ff @(posedge clock) begin
    if (systemReset) begin
      r_param[0] <= T_ARM_DELAY_DEFAULT;
      r_param[1] <= T_DRIVER_DELAY_DEFAULT;
      r_param[2] <= T_PASSENGER_DELAY_DEFAULT;
      r_param[3] <= T_ALARM_ON_DEFAULT;
    end else if (w_write) begin
      r_param[bus.timeParameterSelector] <= bus.timeValue;
    end
  end

  assign bus.value = r_param[bus.interval];

endmodule

// File: tb/tb_time_parameters_with_reprogrammability.sv
// Self-checking bench: directed test-plan scenarios then random traffic,
// compared against a behavioural model of the parameter store.
module tb_time_parameters_with_reprogrammability;

  logic clock;
  logic systemReset;

  time_parameters_with_reprogrammability_if bus ();

  time_parameters_with_reprogrammability dut (
    .clock       (clock),
    .systemReset (systemReset),
    .bus         (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] m_param [4];
  logic       m_prev_rp = 1'b0;
  bit         m_valid   = 1'b0;
  logic [3:0] pre_val, post_val;
  logic [3:0] dflt [4];
  logic [3:0] wval [4];

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model of one rising edge, from the stated rules.
  task automatic model_edge(input logic rst, input logic rp,
                            input logic [1:0] sel, input logic [3:0] tv);
    bit wr;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_param[i] = dflt[i];
      m_prev_rp = 1'b0;
      m_valid   = 1'b1;
    end else begin
`ifdef TPR_REPROG_EDGE_EN
      wr = rp && !m_prev_rp;
`else
      wr = rp;
`endif
      if (wr) m_param[sel] = tv;
      m_prev_rp = rp;
    end
  endtask

  task automatic cyc(input logic rst, input logic rp, input logic [1:0] sel,
                     input logic [3:0] tv, input logic [1:0] itv);
    @(negedge clock);
    systemReset               = rst;
    bus.reprogram             = rp;
    bus.timeParameterSelector = sel;
    bus.timeValue             = tv;
    bus.interval              = itv;
    #1;
    pre_val = bus.value;
    if (m_valid) check("pre_edge", pre_val, m_param[itv]);
    @(posedge clock);
    model_edge(rst, rp, sel, tv);
    #1;
    post_val = bus.value;
    check("post_edge", post_val, m_param[itv]);
  endtask

  initial begin
    dflt[0] = 4'd6;  dflt[1] = 4'd8;  dflt[2] = 4'd15; dflt[3] = 4'd10;
    wval[0] = 4'd7;  wval[1] = 4'd4;  wval[2] = 4'd14; wval[3] = 4'd9;
    systemReset = 1'b0;
    bus.reprogram = 1'b0;
    bus.timeParameterSelector = 2'd0;
    bus.timeValue = 4'd0;
    bus.interval = 2'd0;

    // default readback
    cyc(1'b1, 1'b0, 2'd0, 4'd0, 2'd0);
    cyc(1'b1, 1'b0, 2'd0, 4'd0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 2'd0, 4'd0, 2'(i));
      check("default", post_val, dflt[i]);
    end

    // reprogram every index with 12-cycle pulses
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 12; k++) cyc(1'b0, 1'b1, 2'(i), wval[i], 2'd0);
      cyc(1'b0, 1'b0, 2'(i), wval[i], 2'd0);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 2'd0, 4'd0, 2'(i));
      check("reprog_sweep", post_val, wval[i]);
    end

    // isolation
    cyc(1'b1, 1'b0, 2'd0, 4'd0, 2'd0);
    cyc(1'b0, 1'b1, 2'd3, 4'd3, 2'd0);
    check("iso_pre", pre_val, 4'd6);
    check("iso_post", post_val, 4'd6);
    cyc(1'b0, 1'b0, 2'd3, 4'd3, 2'd3);
    check("iso_idx3", post_val, 4'd3);

    // same-index update
    cyc(1'b0, 1'b1, 2'd1, 4'd12, 2'd1);
    check("same_old", pre_val, 4'd8);
    check("same_new", post_val, 4'd12);
    cyc(1'b0, 1'b0, 2'd1, 4'd12, 2'd1);

    // reset priority over write
    cyc(1'b1, 1'b1, 2'd2, 4'd1, 2'd2);
    check("rst_prio", post_val, 4'd15);
    cyc(1'b0, 1'b0, 2'd0, 4'd0, 2'd1);
    check("rst_restore", post_val, 4'd8);

    // held reprogram with changing timeValue
    cyc(1'b0, 1'b1, 2'd0, 4'd5, 2'd0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 2'd0, 4'd2, 2'd0);
    cyc(1'b0, 1'b0, 2'd0, 4'd2, 2'd0);
`ifdef TPR_REPROG_EDGE_EN
    check("hold_edge", post_val, 4'd5);
`else
    check("hold_level", post_val, 4'd2);
`endif

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 31) == 0), ($urandom_range(0, 2) != 0),
          2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
          2'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
